// File: rtl/crossbar_param.sv
// crossbar_param: N_MST x N_SLV request crossbar with per-slave round-robin
// arbitration, grant locking until accept, and in-order read-data return.
module crossbar_param #(
  parameter int N_MST    = 4,
  parameter int N_SLV    = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_MST-1:0]      m_req,
  input  logic [N_MST-1:0]      m_cmd,
  input  logic [N_MST*AW-1:0]   m_addr,
  input  logic [N_MST*DW-1:0]   m_wdata,
  output logic [N_MST-1:0]      m_ack,
  output logic [N_MST-1:0]      m_resp,
  output logic [N_MST*DW-1:0]   m_rdata,
  output logic [N_SLV-1:0]      s_req,
  output logic [N_SLV-1:0]      s_cmd,
  output logic [N_SLV*AW-1:0]   s_addr,
  output logic [N_SLV*DW-1:0]   s_wdata,
  input  logic [N_SLV-1:0]      s_ack,
  input  logic [N_SLV-1:0]      s_resp,
  input  logic [N_SLV*DW-1:0]   s_rdata
);
  localparam int SW = $clog2(N_SLV);
  localparam int IW = $clog2(N_MST);
  localparam int PW = $clog2(RD_DEPTH);
  localparam int OW = $clog2(RD_DEPTH + 1);
  localparam int CW = $clog2(N_SLV * RD_DEPTH + 1);
  typedef enum logic {IDLE, LOCK} state_t;
  logic [SW-1:0]    tgt    [N_MST];
  logic [SW-1:0]    last_q [N_MST];
  logic [CW-1:0]    cnt_q  [N_MST];
  logic [N_MST-1:0] rd_hs;
  logic [N_SLV-1:0] gv, hs, pop;
  logic [IW-1:0]    gi   [N_SLV];
  logic [IW-1:0]    head [N_SLV];
  for (genvar i = 0; i < N_MST; i++) begin : g_tgt
    assign tgt[i] = m_addr[i*AW+AW-1 -: SW];
  end
  always_comb begin
    m_ack   = '0;
    m_resp  = '0;
    m_rdata = '0;
    rd_hs   = '0;
    for (int i = 0; i < N_MST; i++)
      for (int s = 0; s < N_SLV; s++) begin
        if (hs[s] && gi[s] == IW'(i)) begin
          m_ack[i] = 1'b1;
          rd_hs[i] = !m_cmd[i];
        end
        if (pop[s] && head[s] == IW'(i)) begin
          m_resp[i] = 1'b1;
          m_rdata[i*DW +: DW] = s_rdata[s*DW +: DW];
        end
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < N_MST; i++) begin
        cnt_q[i]  <= '0;
        last_q[i] <= '0;
      end
    else
      for (int i = 0; i < N_MST; i++) begin
        cnt_q[i] <= cnt_q[i] + CW'(rd_hs[i]) - CW'(m_resp[i]);
        if (rd_hs[i]) last_q[i] <= tgt[i];
      end
  for (genvar s = 0; s < N_SLV; s++) begin : g_slv
    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, lidx_q, sel_i, j;
    logic [N_MST-1:0] el;
    logic             sel_v, full, empty, push;
    logic [OW-1:0]    occ_q;
    logic [PW-1:0]    wp_q, rp_q;
    logic [IW-1:0]    mem [RD_DEPTH];
    assign full  = occ_q == OW'(RD_DEPTH);
    assign empty = occ_q == '0;
    // A read may only go out if returns for that master stay on one slave.
    always_comb begin
      el    = '0;
      sel_v = 1'b0;
      sel_i = '0;
      j     = '0;
      for (int i = 0; i < N_MST; i++)
        el[i] = m_req[i] && tgt[i] == SW'(s) &&
                (m_cmd[i] || (!full && (cnt_q[i] == '0 || last_q[i] == SW'(s))));
      for (int k = N_MST - 1; k >= 0; k--) begin
        j = IW'((int'(ptr_q) + k) % N_MST);
        if (el[j]) begin
          sel_v = 1'b1;
          sel_i = j;
        end
      end
    end
    assign gv[s]   = !reset && (state_q == LOCK || sel_v);
    assign gi[s]   = state_q == LOCK ? lidx_q : sel_i;
    assign hs[s]   = gv[s] && s_ack[s];
    assign push    = hs[s] && !m_cmd[gi[s]];
    assign pop[s]  = !reset && s_resp[s] && !empty;
    assign head[s] = mem[rp_q];
    assign s_req[s] = gv[s];
    assign s_cmd[s] = gv[s] && m_cmd[gi[s]];
    assign s_addr[s*AW +: AW]  = gv[s] ? m_addr[gi[s]*AW +: AW] : '0;
    assign s_wdata[s*DW +: DW] = gv[s] ? m_wdata[gi[s]*DW +: DW] : '0;
    always_comb state_d = (gv[s] && !s_ack[s]) ? LOCK : IDLE;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        state_q <= IDLE;
        ptr_q   <= '0;
        lidx_q  <= '0;
        occ_q   <= '0;
        wp_q    <= '0;
        rp_q    <= '0;
      end else begin
        state_q <= state_d;
        if (gv[s]) lidx_q <= gi[s];
        if (hs[s]) ptr_q <= IW'((int'(gi[s]) + 1) % N_MST);
        if (push) wp_q <= wp_q + PW'(1);
        if (pop[s]) rp_q <= rp_q + PW'(1);
        occ_q <= occ_q + OW'(push) - OW'(pop[s]);
      end
    always_ff @(posedge clk)
      if (push) mem[wp_q] <= gi[s];
  end
endmodule
